// File: rtl/l1_fill_ctrl.sv
// L1 cache-side bus controller: sequences line fills, uncached reads and write-throughs onto a single-beat bus.
// Optional ack-wait watchdog enabled by defining L1_CTRL_TIMEOUT_EN.
module l1_fill_ctrl #(
  parameter int unsigned LINE_BYTES = 2048,
  parameter int unsigned BEAT_BYTES = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_line_req,
  input  logic        read_req,
  input  logic        write_through_req,
  input  logic [3:0]  L1_size,
  input  logic [63:0] pa,
  input  logic [63:0] wt_data,
  output logic [63:0] line_data,
  output logic [10:0] addr_count,
  output logic        line_write,
  output logic        cache_entry_write,
  output logic        trans_rdy,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [3:0]  bus_size,
  output logic [63:0] bus_wdata,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  localparam int unsigned BEATS = LINE_BYTES / BEAT_BYTES;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LINE = 3'd1;
  localparam logic [2:0] S_SRD  = 3'd2;
  localparam logic [2:0] S_SWR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]       state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_nxt;
  logic             line_mode;
  logic             tmo_hit;
  logic             beat_fail;

  assign beat_nxt  = beat_cnt + 1'b1;
  assign beat_fail = bus_err | tmo_hit;

  // Completion pulses are pure state decodes, so reset and abandonment can never emit them.
  assign trans_rdy         = (state == S_DONE);
  assign cache_entry_write = (state == S_DONE) && line_mode;
  assign bus_error         = (state == S_ERR);

`ifdef L1_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // An ack in the limit cycle still wins; the watchdog only fires on a silent cycle.
  assign tmo_hit = bus_req && !bus_ack && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !bus_req || bus_ack || bus_err) tmo_cnt <= '0;
    else                                      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      line_mode  <= 1'b0;
      line_data  <= '0;
      addr_count <= '0;
      line_write <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_size   <= '0;
      bus_wdata  <= '0;
    end else begin
      line_write <= 1'b0;
      case (state)
        S_IDLE: begin
          line_mode <= 1'b0;
          if (read_line_req) begin
            state     <= S_LINE;
            line_mode <= 1'b1;
            beat_cnt  <= '0;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_size  <= 4'b1000;
            bus_addr  <= {pa[63:OFF_W], {OFF_W{1'b0}}};
          end else if (read_req) begin
            state    <= S_SRD;
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_size <= L1_size;
            bus_addr <= pa;
          end else if (write_through_req) begin
            state     <= S_SWR;
            bus_req   <= 1'b1;
            bus_we    <= 1'b1;
            bus_size  <= L1_size;
            bus_addr  <= pa;
            bus_wdata <= wt_data;
          end
        end

        S_LINE, S_SRD, S_SWR: begin
          if (bus_req) begin
            if (beat_fail) begin
              bus_req <= 1'b0;
              state   <= S_ERR;
            end else if (bus_ack) begin
              if (state == S_SWR) begin
                bus_req <= 1'b0;
                state   <= S_DONE;
              end else if (state == S_SRD) begin
                line_data <= bus_rdata;
                bus_req   <= 1'b0;
                state     <= S_DONE;
              end else begin
                line_data  <= bus_rdata;
                line_write <= 1'b1;
                addr_count <= 11'({beat_cnt, 3'b000});
                if (beat_cnt == LAST_BEAT) begin
                  bus_req <= 1'b0;
                end else begin
                  beat_cnt              <= beat_nxt;
                  bus_addr[OFF_W-1:3]   <= beat_nxt;
                end
              end
            end
          end else if (state == S_LINE) begin
            // Last line word written in the previous cycle; entry update follows it.
            state <= S_DONE;
          end
        end

        S_DONE, S_ERR: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_fill_ctrl.sv
// Self-checking bench for l1_fill_ctrl: transaction-level model plus a responding bus slave.
module tb_l1_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_line_req = 1'b0, read_req = 1'b0, write_through_req = 1'b0;
  logic [3:0]  L1_size = '0;
  logic [63:0] pa = '0, wt_data = '0;
  logic [63:0] line_data;
  logic [10:0] addr_count;
  logic        line_write, cache_entry_write, trans_rdy, bus_error;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr, bus_wdata;
  logic [3:0]  bus_size;
  logic [63:0] bus_rdata = '0;
  logic        bus_ack = 1'b0, bus_err = 1'b0;

  always #5 clk = ~clk;

  l1_fill_ctrl dut (
    .clk(clk), .rst(rst),
    .read_line_req(read_line_req), .read_req(read_req), .write_through_req(write_through_req),
    .L1_size(L1_size), .pa(pa), .wt_data(wt_data),
    .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
    .cache_entry_write(cache_entry_write), .trans_rdy(trans_rdy), .bus_error(bus_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_size(bus_size),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  typedef enum int {K_LINE, K_RD, K_WR} kind_e;

  int checks = 0, failures = 0;
  int cyc = 0;

  // Transaction model
  kind_e       m_kind = K_LINE;
  bit          m_active = 1'b0, m_drained = 1'b0;
  int          m_req_from = 0, m_beat = 0;
  logic [63:0] m_base = '0, m_wdata = '0;
  logic [3:0]  m_size = '0;
  int          exp_lw_at = -1, exp_done_at = -1, exp_err_at = -1;
  logic [10:0] exp_lw_ac = '0;
  logic [63:0] exp_lw_data = '0, exp_rd_data = '0;
  bit          exp_cew = 1'b0;

  // Slave behaviour and observations
  int          cfg_wait = 0, cfg_err_beat = -1, wc = 0;
  bit          cfg_fixed = 1'b0;
  logic [63:0] cfg_rdata = '0;
  int          lw_count = 0, tr_count = 0, err_count = 0, cew_count = 0, req_cycles = 0;
  int          last_lw_cyc = 0, tr_cyc = 0, ack_cyc = 0;
  logic [63:0] first_addr = '0, last_addr = '0, tr_data = '0;
  logic [10:0] last_ac = '0;
  bit          seen_req = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] rdata_of(input logic [63:0] a);
    return cfg_fixed ? cfg_rdata : {a[31:0] ^ 32'hC3A5_96F0, a[31:0] + 32'h1357_9BDF};
  endfunction

  task automatic tick();
    logic        exp_req;
    logic [63:0] exp_addr;
    @(negedge clk);
    cyc++;
    if (rst) begin
      m_active = 1'b0; exp_lw_at = -1; exp_done_at = -1; exp_err_at = -1;
      bus_ack = 1'b0; bus_err = 1'b0; wc = 0;
      return;
    end
    exp_req  = m_active && (cyc >= m_req_from) && !m_drained;
    exp_addr = (m_kind == K_LINE) ? m_base + 64'(8 * m_beat) : m_base;
    check("bus_req", bus_req, exp_req);
    if (exp_req && bus_req) begin
      check("bus_addr", bus_addr, exp_addr);
      check("bus_we", bus_we, m_kind == K_WR);
      check("bus_size", bus_size, m_size);
      if (m_kind == K_WR) check("bus_wdata", bus_wdata, m_wdata);
      if (!seen_req) first_addr = bus_addr;
      seen_req  = 1'b1;
      last_addr = bus_addr;
      req_cycles++;
    end
    check("line_write", line_write, cyc == exp_lw_at);
    if (line_write) begin
      lw_count++; last_lw_cyc = cyc; last_ac = addr_count;
      if (cyc == exp_lw_at) begin
        check("addr_count", addr_count, exp_lw_ac);
        check("line_data", line_data, exp_lw_data);
      end
    end
    check("trans_rdy", trans_rdy, cyc == exp_done_at);
    check("cache_entry_write", cache_entry_write, (cyc == exp_done_at) && exp_cew);
    check("bus_error", bus_error, cyc == exp_err_at);
    if (trans_rdy) begin tr_count++; tr_cyc = cyc; tr_data = line_data; end
    if (cache_entry_write) cew_count++;
    if (bus_error) err_count++;
    if (trans_rdy && m_kind == K_RD && cyc == exp_done_at) check("rd_line_data", line_data, exp_rd_data);
    if (cyc == exp_done_at || cyc == exp_err_at) m_active = 1'b0;

    bus_ack = 1'b0; bus_err = 1'b0;
    if (bus_req) begin
      if (wc >= cfg_wait) begin
        wc = 0; ack_cyc = cyc;
        bus_rdata = rdata_of(bus_addr);
        bus_ack = 1'b1;
        if (exp_req && m_beat == cfg_err_beat) bus_err = 1'b1;
        if (exp_req) begin
          if (bus_err) begin
            m_drained = 1'b1; exp_err_at = cyc + 1;
          end else begin
            case (m_kind)
              K_LINE: begin
                exp_lw_at = cyc + 1; exp_lw_ac = 11'(8 * m_beat); exp_lw_data = bus_rdata;
                m_beat++;
                if (m_beat == 256) begin m_drained = 1'b1; exp_done_at = cyc + 2; exp_cew = 1'b1; end
              end
              K_RD: begin exp_rd_data = bus_rdata; m_drained = 1'b1; exp_done_at = cyc + 1; end
              default: begin m_drained = 1'b1; exp_done_at = cyc + 1; end
            endcase
          end
        end
      end else begin
        wc++;
      end
    end else begin
      wc = 0;
    end
  endtask

  task automatic start(input kind_e k, input logic [63:0] a, input logic [3:0] sz,
                       input logic [63:0] wd, input logic [2:0] strobes);
    m_kind = k; m_active = 1'b1; m_req_from = cyc + 1; m_drained = 1'b0; m_beat = 0;
    m_base = (k == K_LINE) ? {a[63:11], 11'b0} : a;
    m_size = (k == K_LINE) ? 4'b1000 : sz;
    m_wdata = wd; exp_cew = 1'b0;
    pa = a; L1_size = sz; wt_data = wd;
    {read_line_req, read_req, write_through_req} = strobes;
    seen_req = 1'b0; lw_count = 0; tr_count = 0; err_count = 0; cew_count = 0; req_cycles = 0;
  endtask

  task automatic run_to_end(input int budget);
    int n = 0;
    while (m_active && n < budget) begin tick(); n++; end
    if (m_active) check("transfer_finished_in_budget", 64'd0, 64'd1);
    {read_line_req, read_req, write_through_req} = 3'b000;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_line_data"}, line_data, 64'd0);
    check({tag, "_addr_count"}, addr_count, 64'd0);
    check({tag, "_line_write"}, line_write, 64'd0);
    check({tag, "_cache_entry_write"}, cache_entry_write, 64'd0);
    check({tag, "_trans_rdy"}, trans_rdy, 64'd0);
    check({tag, "_bus_error"}, bus_error, 64'd0);
    check({tag, "_bus_req"}, bus_req, 64'd0);
    check({tag, "_bus_we"}, bus_we, 64'd0);
    check({tag, "_bus_addr"}, bus_addr, 64'd0);
    check({tag, "_bus_size"}, bus_size, 64'd0);
    check({tag, "_bus_wdata"}, bus_wdata, 64'd0);
  endtask

  initial begin
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Line fill, zero-wait acks, all strobes high to exercise priority.
    cfg_wait = 0; cfg_err_beat = -1; cfg_fixed = 1'b0;
    start(K_LINE, 64'h0000_0000_8000_0A38, 4'b0001, 64'h0, 3'b111);
    run_to_end(400);
    check("fill_lw_count", lw_count, 256);
    check("fill_first_addr", first_addr, 64'h8000_0800);
    check("fill_last_addr", last_addr, 64'h8000_0FF8);
    check("fill_last_addr_count", last_ac, 11'd2040);
    check("fill_trans_rdy_count", tr_count, 1);
    check("fill_cew_count", cew_count, 1);
    check("fill_done_after_last_lw", tr_cyc - last_lw_cyc, 1);

    // Single read with three wait cycles; read_req outranks write_through_req.
    cfg_wait = 3; cfg_fixed = 1'b1; cfg_rdata = 64'h0000_0000_DEAD_BEEF;
    start(K_RD, 64'h1000_0004, 4'b0100, 64'h0, 3'b011);
    run_to_end(40);
    check("rd_req_cycles", req_cycles, 4);
    check("rd_trans_rdy_data", tr_data, 64'h0000_0000_DEAD_BEEF);
    check("rd_lw_count", lw_count, 0);
    check("rd_cew_count", cew_count, 0);
    check("rd_done_after_ack", tr_cyc - ack_cyc, 1);

    // Write-through with two wait cycles.
    cfg_wait = 2; cfg_fixed = 1'b0;
    start(K_WR, 64'h2000_0008, 4'b1000, 64'h1122_3344_5566_7788, 3'b001);
    run_to_end(40);
    check("wr_req_cycles", req_cycles, 3);
    check("wr_trans_rdy_count", tr_count, 1);
    check("wr_lw_count", lw_count, 0);
    check("wr_done_after_ack", tr_cyc - ack_cyc, 1);

    // Line fill failing on beat 5 (err and ack together).
    cfg_wait = 0; cfg_err_beat = 5;
    start(K_LINE, 64'h0000_0000_4000_1234, 4'b1000, 64'h0, 3'b100);
    run_to_end(40);
    check("err_lw_count", lw_count, 5);
    check("err_last_addr_count", last_ac, 11'd32);
    check("err_bus_error_count", err_count, 1);
    check("err_trans_rdy_count", tr_count, 0);
    check("err_cew_count", cew_count, 0);
    check("err_bus_req_low", bus_req, 1'b0);

    // Reset in the middle of a fill, then a normal read.
    cfg_err_beat = -1;
    start(K_LINE, 64'h0000_0000_9000_0000, 4'b1000, 64'h0, 3'b100);
    for (int n = 0; n < 400 && m_beat < 100; n++) tick();
    check("rst_reached_beat_100", m_beat, 100);
    rst = 1'b1;
    {read_line_req, read_req, write_through_req} = 3'b000;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    tick();
    cfg_wait = 1;
    start(K_RD, 64'h3000_0010, 4'b0010, 64'h0, 3'b010);
    run_to_end(40);
    check("post_rst_rd_done", tr_count, 1);
    check("post_rst_no_error", err_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1_fill_ctrl.md
Name: l1_fill_ctrl

Overview:
- Cache-side bus controller for the L1 data/instruction cache.
- Accepts the L1 miss/uncached request strobes (read_line_req, read_req, write_through_req) and sequences them onto a single-outstanding-beat system bus master port.
- For line fills, generates per-beat cache write strobes and offsets (line_write, addr_count, line_data), then a final entry-update and completion handshake (cache_entry_write, trans_rdy) or a bus_error pulse.

Parameters:
- LINE_BYTES, 2048, bytes per cache line; power of 2.
- BEAT_BYTES, 8, bytes per bus beat; fixed to the 64-bit data path.
- TIMEOUT, 1024, ack-wait limit in cycles; used only with L1_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- read_line_req  in  1  L1 requests a line fill
- read_req  in  1  L1 requests a single uncached read
- write_through_req  in  1  L1 requests a single write-through
- L1_size  in  4  access size, one-hot: 0001=1B, 0010=2B, 0100=4B, 1000=8B
- pa  in  64  physical address
- wt_data  in  64  write-through data
- line_data  out  64  captured bus read data
- addr_count  out  11  byte offset within line of the current line_write
- line_write  out  1  cache line-word write strobe
- cache_entry_write  out  1  update tag entry, one-cycle pulse
- trans_rdy  out  1  transfer complete, one-cycle pulse
- bus_error  out  1  transfer failed, one-cycle pulse
- bus_req  out  1  bus beat request
- bus_we  out  1  1 = write beat
- bus_addr  out  64  beat address
- bus_size  out  4  beat size, one-hot
- bus_wdata  out  64  write data
- bus_rdata  in  64  read data, valid with bus_ack
- bus_ack  in  1  beat accepted / data valid
- bus_err  in  1  beat failed

Behaviour:
- Reset: state IDLE, beat counter 0. All outputs 0: line_data, addr_count, line_write, cache_entry_write, trans_rdy, bus_error, bus_req, bus_we, bus_addr, bus_size, bus_wdata.
- Reset mid-operation:
  - Same values as reset, including bus_req dropping immediately.
  - No trans_rdy or bus_error is produced.
  - The bus tolerates an abandoned beat.
- States: IDLE, LINE, SRD, SWR, DONE, ERR.
- IDLE:
  - Samples requests with priority read_line_req > read_req > write_through_req.
  - LINE: next cycle bus_req=1, bus_we=0, bus_size=1000, bus_addr={pa[63:11],11'b0}, beat counter 0.
  - SRD: bus_req=1, bus_we=0, bus_addr=pa, bus_size=L1_size.
  - SWR: bus_req=1, bus_we=1, bus_addr=pa, bus_size=L1_size, bus_wdata=wt_data.
- Bus rules:
  - bus_req, bus_addr, bus_we, bus_size and bus_wdata are held stable until bus_ack or bus_err is sampled high.
  - bus_ack may arrive in the same cycle bus_req first rises.
  - bus_err takes precedence over a simultaneous bus_ack.
- LINE, on bus_ack for beat k:
  - Next cycle: line_write=1 (one cycle), line_data=bus_rdata, addr_count=8*k.
  - If k < LINE_BYTES/BEAT_BYTES-1: bus_addr advances by 8 in that same next cycle and bus_req stays high, so zero-wait acks give one beat per cycle.
  - On the ack of the last beat (k=255): bus_req drops next cycle, then state DONE.
- DONE:
  - Lasts one cycle with trans_rdy=1.
  - cache_entry_write=1 only when entered from LINE.
  - Then IDLE.
  - For a line fill, DONE is the cycle after the last line_write.
- SRD, on bus_ack: line_data=bus_rdata and bus_req=0 next cycle, with state DONE. line_data stays valid through the trans_rdy cycle and holds until the next capture.
- SWR, on bus_ack: bus_req=0, then DONE. line_write stays 0.
- Any state, on bus_err: next cycle bus_req=0 and state ERR.
  - ERR asserts bus_error=1 for one cycle, then IDLE.
  - No further line_write, no cache_entry_write, no trans_rdy.
  - line_write for beats already acked has already occurred.
- Request-strobe handling:
  - Strobes are sampled only in IDLE; changes during a transfer are ignored.
  - The L1 drops its strobe after seeing trans_rdy/bus_error, so IDLE never re-triggers on a stale request.
- Arithmetic:
  - Beat counter is 8 bits (LINE_BYTES/BEAT_BYTES beats), wrapping never occurs.
  - addr_count = counter<<3 truncated to 11 bits.
  - bus_addr increments touch only bits [10:3].

Optional Feature:
- Macro L1_CTRL_TIMEOUT_EN.
- Defined:
  - A counter clears on each bus_req rising edge and on each ack, and increments while bus_req=1 without ack/err.
  - Reaching TIMEOUT is treated exactly as bus_err: next cycle ERR, then a bus_error pulse.
- Undefined: no counter; the controller waits indefinitely for ack/err.

Test Plan:
- Line fill, pa=0x0000_0000_8000_0A38, bus_ack every cycle ->
  - bus_addr 0x8000_0800 to 0x8000_0FF8.
  - 256 line_write pulses with addr_count 0,8,…,2040 and line_data equal to bus_rdata each.
  - cache_entry_write=trans_rdy=1 in the single cycle after the last line_write.
- Single read, pa=0x1000_0004, L1_size=0100, ack after 3 wait cycles with rdata=0xDEAD_BEEF ->
  - bus_size=0100, bus_we=0.
  - line_data=0xDEAD_BEEF in the trans_rdy cycle.
  - No line_write, no cache_entry_write.
- Write-through, pa=0x2000_0008, wt_data=0x1122334455667788, L1_size=1000 ->
  - bus_we=1, bus_wdata held until ack.
  - trans_rdy one cycle after ack, line_write never asserted.
- Line fill with bus_err on beat 5 ->
  - Exactly 5 line_write pulses (addr_count 0..32).
  - bus_error pulse, no trans_rdy, no cache_entry_write, bus_req low after the error.
- rst asserted at beat 100 of a fill ->
  - All outputs 0 next cycle.
  - A following read_req completes normally.
- With L1_CTRL_TIMEOUT_EN and TIMEOUT=16, read_req with no ack -> bus_req high for 16 cycles, then bus_error pulse.
